// File: rtl/rob_commit_unit_pkg.sv
// Shared encodings for the ROB commit consumer: instruction types, exception
// causes, privileged-register indices and the commit-unit state enum.
package rob_commit_unit_pkg;

    localparam logic [2:0] INSTR_TYPE_ALU    = 3'd0;
    localparam logic [2:0] INSTR_TYPE_MUL    = 3'd1;
    localparam logic [2:0] INSTR_TYPE_LOAD   = 3'd2;
    localparam logic [2:0] INSTR_TYPE_STORE  = 3'd3;
    localparam logic [2:0] INSTR_TYPE_BRANCH = 3'd4;
    localparam logic [2:0] INSTR_TYPE_JUMP   = 3'd5;
    localparam logic [2:0] INSTR_TYPE_IRET   = 3'd6;
    localparam logic [2:0] INSTR_TYPE_NOP    = 3'd7;

    localparam logic [2:0] EXCEPTION_TYPE_NONE     = 3'b000;
    localparam logic [2:0] EXCEPTION_TYPE_ITLB     = 3'b001;
    localparam logic [2:0] EXCEPTION_TYPE_DTLBMISS = 3'b010;
    localparam logic [2:0] EXCEPTION_TYPE_ILLEGAL  = 3'b011;
    localparam logic [2:0] EXCEPTION_TYPE_PRIV     = 3'b100;
    localparam logic [2:0] EXCEPTION_TYPE_SYSCALL  = 3'b101;

    localparam logic [2:0] RM_EPC   = 3'd0;
    localparam logic [2:0] RM_ADDR  = 3'd1;
    localparam logic [2:0] RM_CAUSE = 3'd2;
    localparam logic [2:0] RM_MODE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAVE_PC    = 3'd1,
        ST_SAVE_ADDR  = 3'd2,
        ST_SAVE_CAUSE = 3'd3,
        ST_ENTER      = 3'd4,
        ST_IRET       = 3'd5
    } commit_state_e;

    function automatic logic is_writeback_type(input logic [2:0] t);
        return (t == INSTR_TYPE_ALU) || (t == INSTR_TYPE_MUL) || (t == INSTR_TYPE_LOAD);
    endfunction

endpackage

// File: rtl/rob_commit_unit_exc_fsm.sv
// Exception-entry / IRET sequencer: state register, fault latches, epc shadow,
// supervisor bit and the registered priv-write / redirect / flush / stall outputs.
module commit_exc_fsm
    import rob_commit_unit_pkg::*;
#(
    parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_2000,
    parameter int          CAUSE_W        = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_exc_start,
    input  logic               i_iret_start,
    input  logic [31:0]        i_pc,
    input  logic [31:0]        i_miss_addr,
    input  logic [CAUSE_W-1:0] i_cause,
    output logic [2:0]         o_state,
    output logic               o_priv_we,
    output logic [2:0]         o_priv_idx,
    output logic [31:0]        o_priv_wdata,
    output logic               o_redirect_valid,
    output logic [31:0]        o_redirect_pc,
    output logic               o_flush,
    output logic               o_stall,
    output logic               o_supervisor
);

    commit_state_e      r_state;
    commit_state_e      w_next;
    logic [31:0]        r_epc;
    logic [31:0]        r_addr;
    logic [CAUSE_W-1:0] r_cause;
    logic               r_supervisor;

    logic               r_priv_we;
    logic [2:0]         r_priv_idx;
    logic [31:0]        r_priv_wdata;
    logic               r_redirect_valid;
    logic [31:0]        r_redirect_pc;
    logic               r_flush;
    logic               r_stall;

    logic               w_priv_we;
    logic [2:0]         w_priv_idx;
    logic [31:0]        w_priv_wdata;
    logic               w_redirect_valid;
    logic [31:0]        w_redirect_pc;
    logic               w_flush;
    logic               w_supervisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the next state so each side effect lands in
    // the cycle the sequence occupies that state.
    always_comb begin
        w_next           = r_state;
        w_priv_we        = 1'b0;
        w_priv_idx       = 3'd0;
        w_priv_wdata     = 32'd0;
        w_redirect_valid = 1'b0;
        w_redirect_pc    = 32'd0;
        w_flush          = 1'b0;
        w_supervisor     = r_supervisor;

        case (r_state)
            ST_IDLE: begin
                if (i_iret_start) begin
                    w_next = ST_IRET;
                end else if (i_exc_start) begin
                    w_next = ST_SAVE_PC;
                end
            end
            ST_SAVE_PC:    w_next = ST_SAVE_ADDR;
            ST_SAVE_ADDR:  w_next = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE: w_next = ST_ENTER;
            ST_ENTER:      w_next = ST_IDLE;
            ST_IRET:       w_next = ST_IDLE;
            default:       w_next = ST_IDLE;
        endcase

        case (w_next)
            ST_SAVE_PC: begin
                w_priv_we    = 1'b1;
                w_priv_idx   = RM_EPC;
                w_priv_wdata = i_pc;
            end
            ST_SAVE_ADDR: begin
                w_priv_we    = 1'b1;
                w_priv_idx   = RM_ADDR;
                w_priv_wdata = r_addr;
            end
            ST_SAVE_CAUSE: begin
                w_priv_we    = 1'b1;
                w_priv_idx   = RM_CAUSE;
                w_priv_wdata = {{(32-CAUSE_W){1'b0}}, r_cause};
            end
            ST_ENTER: begin
                w_priv_we        = 1'b1;
                w_priv_idx       = RM_MODE;
                w_priv_wdata     = 32'd1;
                w_redirect_valid = 1'b1;
                w_redirect_pc    = EXC_HANDLER_PC;
                w_flush          = 1'b1;
                w_supervisor     = 1'b1;
            end
            ST_IRET: begin
                w_redirect_valid = 1'b1;
                w_redirect_pc    = r_epc;
                w_flush          = 1'b1;
                w_supervisor     = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_epc            <= 32'd0;
            r_addr           <= 32'd0;
            r_cause          <= '0;
            r_supervisor     <= 1'b0;
            r_priv_we        <= 1'b0;
            r_priv_idx       <= 3'd0;
            r_priv_wdata     <= 32'd0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_flush          <= 1'b0;
            r_stall          <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_next == ST_SAVE_PC) begin
                r_epc   <= i_pc;
                r_addr  <= i_miss_addr;
                r_cause <= i_cause;
            end
            r_supervisor     <= w_supervisor;
            r_priv_we        <= w_priv_we;
            r_priv_idx       <= w_priv_idx;
            r_priv_wdata     <= w_priv_wdata;
            r_redirect_valid <= w_redirect_valid;
            r_redirect_pc    <= w_redirect_pc;
            r_flush          <= w_flush;
            r_stall          <= (w_next != ST_IDLE);
        end
    end

    assign o_state          = r_state;
    assign o_priv_we        = r_priv_we;
    assign o_priv_idx       = r_priv_idx;
    assign o_priv_wdata     = r_priv_wdata;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_flush          = r_flush;
    assign o_stall          = r_stall;
    assign o_supervisor     = r_supervisor;

endmodule

// File: rtl/rob_commit_unit.sv
// ROB commit consumer: regfile write, store drain, exception entry and IRET.
// Optional perf counters under ROB_COMMIT_PERF_EN.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter logic [31:0] EXC_HANDLER_PC = 32'h0000_2000,
    parameter int          CAUSE_W        = 3,
    parameter int          PERF_W         = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_commit_valid,
    input  logic [31:0]        in_commit_value,
    input  logic [4:0]         in_commit_rd,
    input  logic [2:0]         in_commit_type,
    input  logic [31:0]        in_commit_pc,
    input  logic [31:0]        in_commit_miss_addr,
    input  logic [CAUSE_W-1:0] in_commit_exc,
    input  logic               in_iret_commit,
    output logic               out_rf_we,
    output logic [4:0]         out_rf_waddr,
    output logic [31:0]        out_rf_wdata,
    output logic               out_sb_drain,
    output logic               out_priv_we,
    output logic [2:0]         out_priv_idx,
    output logic [31:0]        out_priv_wdata,
    output logic               out_redirect_valid,
    output logic [31:0]        out_redirect_pc,
    output logic               out_flush,
    output logic               out_stall,
    output logic               out_supervisor
`ifdef ROB_COMMIT_PERF_EN
    ,
    output logic [PERF_W-1:0]  out_perf_retired,
    output logic [PERF_W-1:0]  out_perf_exceptions
`endif
);

    // Handshake: a commit (or IRET) is consumed only in a cycle where the unit
    // is idle; out_stall is the registered not-ready that holds the ROB head.
    logic [2:0]  w_fsm_state;
    logic        w_idle;
    logic        w_take;
    logic        w_no_exc;
    logic        w_rf_write;
    logic        w_sb_write;

    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_sb_drain;

    assign w_idle     = (w_fsm_state == ST_IDLE);
    assign w_take     = in_commit_valid && w_idle && !in_iret_commit;
    assign w_no_exc   = (in_commit_exc == '0);
    assign w_rf_write = w_take && w_no_exc && is_writeback_type(in_commit_type)
                        && (in_commit_rd != 5'd0);
    assign w_sb_write = w_take && w_no_exc && (in_commit_type == INSTR_TYPE_STORE);

    commit_exc_fsm #(
        .EXC_HANDLER_PC (EXC_HANDLER_PC),
        .CAUSE_W        (CAUSE_W)
    ) u_exc_fsm (
        .clk              (clk),
        .reset            (reset),
        .i_exc_start      (in_commit_valid && !w_no_exc),
        .i_iret_start     (in_iret_commit),
        .i_pc             (in_commit_pc),
        .i_miss_addr      (in_commit_miss_addr),
        .i_cause          (in_commit_exc),
        .o_state          (w_fsm_state),
        .o_priv_we        (out_priv_we),
        .o_priv_idx       (out_priv_idx),
        .o_priv_wdata     (out_priv_wdata),
        .o_redirect_valid (out_redirect_valid),
        .o_redirect_pc    (out_redirect_pc),
        .o_flush          (out_flush),
        .o_stall          (out_stall),
        .o_supervisor     (out_supervisor)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'd0;
            r_sb_drain <= 1'b0;
        end else begin
            r_rf_we    <= w_rf_write;
            r_rf_waddr <= w_rf_write ? in_commit_rd : 5'd0;
            r_rf_wdata <= w_rf_write ? in_commit_value : 32'd0;
            r_sb_drain <= w_sb_write;
        end
    end

    assign out_rf_we    = r_rf_we;
    assign out_rf_waddr = r_rf_waddr;
    assign out_rf_wdata = r_rf_wdata;
    assign out_sb_drain = r_sb_drain;

`ifdef ROB_COMMIT_PERF_EN
    logic [PERF_W-1:0] r_perf_retired;
    logic [PERF_W-1:0] r_perf_exceptions;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_retired    <= '0;
            r_perf_exceptions <= '0;
        end else begin
            if ((w_take && w_no_exc) || (in_iret_commit && w_idle)) begin
                r_perf_retired <= r_perf_retired + 1'b1;
            end
            if (w_take && !w_no_exc) begin
                r_perf_exceptions <= r_perf_exceptions + 1'b1;
            end
        end
    end

    assign out_perf_retired    = r_perf_retired;
    assign out_perf_exceptions = r_perf_exceptions;
`endif

    a_perf_w_nonzero: assert property (@(posedge clk) PERF_W > 0);

    a_iret_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(in_iret_commit && in_commit_valid));

    a_commit_when_idle: assert property (@(posedge clk) disable iff (reset)
        (in_commit_valid || in_iret_commit) |-> w_idle);

endmodule
